// File: rtl/mem_port.sv
// Memory-side stage: owns the program counter, the data address register, the address mux,
// the 256x16 RAM and the memory-mapped LED/switch ports. Read data comes back registered in mdata.
module mem_port #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 16,
  parameter int                RAM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_addr,
  input  logic              addr_sel,
  input  logic [1:0]        mem_cmd,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        switches,
  output logic [DATA_W-1:0] mdata,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        leds,
  output logic              bad_cmd
);

  localparam int              IDX_W     = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W:0] RAM_LIMIT = RAM_DEPTH[ADDR_W:0];

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_BAD   = 2'b11;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [7:0]        leds_q, leds_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic [7:0]        sw_s1_q, sw_s2_q;

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic              ram_hit, led_hit, sw_hit;
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_we;

  assign mem_addr = addr_sel ? pc_q : da_q;

  always_comb begin
    ram_hit = ({1'b0, mem_addr} < RAM_LIMIT);
    led_hit = (mem_addr == LED_ADDR);
    sw_hit  = (mem_addr == SW_ADDR);
    ram_idx = mem_addr[IDX_W-1:0];
  end

  always_comb begin
    pc_d = pc_q;
    if (load_pc) begin
      pc_d = reset_pc ? '0 : pc_q + 1'b1;
    end
    da_d = load_addr ? write_data[ADDR_W-1:0] : da_q;
  end

  // All memory side effects use the pre-edge mem_addr; PC/DA updates land next cycle.
  always_comb begin
    mdata_d   = mdata_q;
    leds_d    = leds_q;
    bad_cmd_d = bad_cmd_q;
    ram_we    = 1'b0;
    case (mem_cmd)
      CMD_READ: begin
        if (ram_hit)     mdata_d = ram[ram_idx];
        else if (sw_hit) mdata_d = {{(DATA_W-8){1'b0}}, sw_s2_q};
        else             mdata_d = '0;
      end
      CMD_WRITE: begin
        if (ram_hit)      ram_we = 1'b1;
        else if (led_hit) leds_d = write_data[7:0];
      end
      CMD_BAD:  bad_cmd_d = 1'b1;
      CMD_NONE: ;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      da_q      <= '0;
      mdata_q   <= '0;
      leds_q    <= '0;
      bad_cmd_q <= 1'b0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      da_q      <= da_d;
      mdata_q   <= mdata_d;
      leds_q    <= leds_d;
      bad_cmd_q <= bad_cmd_d;
      sw_s1_q   <= switches;
      sw_s2_q   <= sw_s1_q;
    end
  end

  // RAM contents survive reset, so the array sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= write_data;
  end

  assign mdata   = mdata_q;
  assign pc      = pc_q;
  assign leds    = leds_q;
  assign bad_cmd = bad_cmd_q;

endmodule
